// File: rtl/hilo_mdu_param.sv
// hilo_mdu_param: HI/LO multiply-divide unit for the EX stage.
// Multiply commits MUL_LAT cycles after start. Divide is a radix-2 restoring
// divider (WIDTH iterations plus one sign-fix cycle).
// Optional feature macro: HILO_MDU_MACC_EN enables MADD/MADDU/MSUB/MSUBU
// (op 7-10). Without it those codes behave as NOP.
module hilo_mdu_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + MUL_LAT) + 1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef HILO_MDU_MACC_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] op_a;      // multiplicand, or original dividend for divide-by-zero
  logic [WIDTH-1:0] op_b;      // multiplier, or divisor magnitude
  logic             mul_signed;
  logic             acc_en;
  logic             acc_sub;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;       // dividend shifts out the top while quotient shifts in
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  // Decoded launch request
  logic is_mul, is_div, dec_signed, dec_acc, dec_sub;

  // Magnitude of an operand, treating it as two's complement only when sgn is set
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  // Op decode for the IDLE launch
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    is_mul     = 1'b0;
    is_div     = 1'b0;
    dec_signed = 1'b0;
    dec_acc    = 1'b0;
    dec_sub    = 1'b0;
    case (op)
      OP_MULT:  begin is_mul = 1'b1; dec_signed = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; dec_signed = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
`ifdef HILO_MDU_MACC_EN
      OP_MADD:  begin is_mul = 1'b1; dec_signed = 1'b1; dec_acc = 1'b1; end
      OP_MADDU: begin is_mul = 1'b1; dec_acc = 1'b1; end
      OP_MSUB:  begin is_mul = 1'b1; dec_signed = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; end
      OP_MSUBU: begin is_mul = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Product and optional accumulate against the HI/LO value current at commit
  logic [2*WIDTH-1:0] ext_a, ext_b, product, mul_result;
  always_comb begin
    ext_a      = mul_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    ext_b      = mul_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
    product    = ext_a * ext_b;
    mul_result = product;
    if (acc_en) mul_result = acc_sub ? ({hi, lo} - product) : ({hi, lo} + product);
  end

  // One restoring step: shift in the next dividend bit, try subtracting the divisor
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [WIDTH-1:0] q_fin, r_fin;
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, op_b};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
    // MIN / -1 needs no special case: |MIN| / 1 = 2^(WIDTH-1), which is MIN again.
    q_fin    = neg_q ? -quo : quo;
    r_fin    = neg_r ? -rem : rem;
  end

  // Control FSM, datapath registers and architectural HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      mul_signed <= 1'b0;
      acc_en     <= 1'b0;
      acc_sub    <= 1'b0;
      rem        <= '0;
      quo        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero   <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            if (is_mul) begin
              op_a       <= a;
              op_b       <= b;
              mul_signed <= dec_signed;
              acc_en     <= dec_acc;
              acc_sub    <= dec_sub;
              count      <= CW'(MUL_LAT - 1);
              busy       <= 1'b1;
              state      <= S_MUL;
            end else if (is_div) begin
              op_a     <= a;
              op_b     <= mag(b, dec_signed);
              quo      <= mag(a, dec_signed);
              rem      <= '0;
              neg_q    <= dec_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r    <= dec_signed && a[WIDTH-1];
              div_zero <= (b == '0);
              count    <= CW'(WIDTH - 1);
              busy     <= 1'b1;
              state    <= S_DIV;
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        S_MUL: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (count == '0) begin
            {hi, lo} <= mul_result;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        S_DIV: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            if (count == '0) state <= S_FIX;
            else             count <= count - 1'b1;
          end
        end
        S_FIX: begin
          busy  <= 1'b0;
          state <= S_IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (div_zero) begin
              lo <= '1;
              hi <= op_a;
            end else begin
              lo <= q_fin;
              hi <= r_fin;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
